serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 113 +++++++++++
 tb/tb_serial_add_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: {c_out,sum} = a + b + c_in, one bit per clock through a single full adder.
// Optional overflow output enabled by defining SERIAL_ADD_OVF_EN.

module fa (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co, last, accept;

  fa u_fa (
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .carry_in (carry),
    .sum      (fa_s),
    .carry_out(fa_co)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && start;

  // The A register doubles as the result register: sum bits enter at the MSB
  // as operand bits leave at the LSB, so after WIDTH shifts it holds the sum.
  assign res_next = WIDTH'({fa_s, a_sh} >> 1);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= c_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= res_next;
        b_sh  <= b_sh >> 1;
        carry <= fa_co;
        cnt   <= cnt + 1'b1;
        // Outputs change only on the final bit; intermediate sums stay hidden.
        if (last) begin
          sum   <= res_next;
          c_out <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf   <= carry ^ fa_co;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized scoreboard bench for serial_add_ctrl: arithmetic reference model, cycle-level busy/done model.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         c_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic         busy, done, c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  res_t q[$];
  res_t held = '0;
  int   checks = 0;
  int   errors = 0;
  int   mb_cnt = 0;
  int   edges = 0;
  int   last_done = -1;
  bit   hold_phase = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .c_out(c_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint u, sg, lim;
    res_t   r;
    u    = longint'(x) + longint'(y) + longint'(c);
    r.s  = u[W-1:0];
    r.co = (u >> W) != 0;
    sg   = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    lim  = longint'(1) <<< (W - 1);
    r.ov = (sg > lim - 1) || (sg < -lim);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted start makes the unit busy for W RUN cycles plus one DONE cycle.
  always @(posedge clk) begin
    edges++;
    if (rst) begin
      mb_cnt = 0;
      q.delete();
      held = '0;
    end else if (mb_cnt == 0) begin
      if (start) begin
        q.push_back(model(a, b, c_in));
        mb_cnt = W + 1;
      end
    end else begin
      mb_cnt--;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, mb_cnt != 0);
    chk("done", done, mb_cnt == 1);
    if (done) begin
      chk("sb_pending", q.size() > 0, 1);
      if (q.size() > 0) held = q.pop_front();
      if (hold_phase && last_done >= 0) chk("restart_period", edges - last_done, W + 2);
      last_done = edges;
    end
    chk("sum", sum, held.s);
    chk("c_out", c_out, held.co);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", ovf, held.ov);
`endif
  end

  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 4 * W) begin
      if (noise) begin
        a     = W'($urandom);
        b     = W'($urandom);
        c_in  = 1'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input bit noise);
    a     = x;
    b     = y;
    c_in  = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(noise);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'h5A, 8'h33, 1'b0, 1'b1);
    do_op(8'hFF, 8'h01, 1'b0, 1'b1);
    do_op(8'h7F, 8'h00, 1'b1, 1'b1);
    do_op(8'h80, 8'h80, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);

    // start pulse during RUN must be ignored
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(1'b0);

    // reset during the 4th RUN cycle aborts the operation
    a = 8'h55; b = 8'h66; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h10, 8'h20, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    end

    // start held high: back-to-back operations
    hold_phase = 1'b1;
    last_done  = -1;
    a = 8'hC3; b = 8'h4D; c_in = 1'b1; start = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    wait_idle(1'b0);
    hold_phase = 1'b0;

    repeat (2) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
